// File: rtl/input_buffer_feeder.sv
// input_buffer_feeder: streams packed pixel words from memory into three channel FIFOs under credit control
// Optional: define INPUT_FEEDER_STALL_CNT_EN to add the stall_cycles counter port.
module input_buffer_feeder #(
    parameter int DAT_WIDTH     = 8,
    parameter int NUM_CHANNEL   = 3,
    parameter int FF_DEPTH      = 8,
    parameter int FF_ADDR_WIDTH = 3,
    parameter int ADDR_WIDTH    = 16,
    parameter int CNT_WIDTH     = 16,
    parameter int MEM_LATENCY   = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [ADDR_WIDTH-1:0]            base_addr,
    input  logic [CNT_WIDTH-1:0]             num_pixels,
    output logic                             busy,
    output logic                             done,
    output logic                             mem_en,
    output logic [ADDR_WIDTH-1:0]            mem_addr,
    input  logic [DAT_WIDTH*NUM_CHANNEL-1:0] mem_rdata,
    output logic [DAT_WIDTH-1:0]             o_data_ch0,
    output logic [DAT_WIDTH-1:0]             o_data_ch1,
    output logic [DAT_WIDTH-1:0]             o_data_ch2,
    output logic                             o_data_ch0_val,
    output logic                             o_data_ch1_val,
    output logic                             o_data_ch2_val,
    input  logic [FF_ADDR_WIDTH-1:0]         data_counter_ch0,
    input  logic [FF_ADDR_WIDTH-1:0]         data_counter_ch1,
    input  logic [FF_ADDR_WIDTH-1:0]         data_counter_ch2
`ifdef INPUT_FEEDER_STALL_CNT_EN
    ,
    output logic [15:0]                      stall_cycles
`endif
);
    localparam int CW = FF_ADDR_WIDTH + 2;
    localparam int PW = MEM_LATENCY + 2;
    localparam logic [CW-1:0] LIMIT = CW'(FF_DEPTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                   state;
    logic [ADDR_WIDTH-1:0]    addr;
    logic [CNT_WIDTH-1:0]     remaining;
    logic [PW-1:0]            pipe;
    logic [FF_ADDR_WIDTH-1:0] max01;
    logic [FF_ADDR_WIDTH-1:0] max_cnt;
    logic [CW-1:0]            in_flight;
    logic [CW-1:0]            level;
    logic                     credit_ok;
    logic                     issue;

    assign mem_en   = issue;
    assign mem_addr = addr;

    // worst-case fill: fullest channel plus words issued but not yet reflected in its counter
    always_comb begin
        max01     = data_counter_ch0 > data_counter_ch1 ? data_counter_ch0 : data_counter_ch1;
        max_cnt   = max01 > data_counter_ch2 ? max01 : data_counter_ch2;
        in_flight = '0;
        for (int i = 0; i < PW; i++) in_flight = in_flight + CW'(pipe[i]);
        level     = CW'(max_cnt) + in_flight;
        credit_ok = level < LIMIT;
        issue     = state == RUN && remaining != '0 && credit_ok;
    end

    // control FSM: accept start, walk addresses, wait for the last word to leave the pipe
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            addr      <= '0;
            remaining <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    if (num_pixels != '0) begin
                        state     <= RUN;
                        busy      <= 1'b1;
                        addr      <= base_addr;
                        remaining <= num_pixels;
                    end else begin
                        done <= 1'b1;
                    end
                end
                RUN: if (issue) begin
                    addr      <= addr + ADDR_WIDTH'(1);
                    remaining <= remaining - CNT_WIDTH'(1);
                    if (remaining == CNT_WIDTH'(1)) state <= DRAIN;
                end
                DRAIN: if (pipe[MEM_LATENCY-1:0] == '0) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // issue shift register doubles as the read-data valid pipeline and the in-flight window
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe           <= '0;
            o_data_ch0_val <= 1'b0;
            o_data_ch1_val <= 1'b0;
            o_data_ch2_val <= 1'b0;
            o_data_ch0     <= '0;
            o_data_ch1     <= '0;
            o_data_ch2     <= '0;
        end else begin
            pipe           <= {pipe[PW-2:0], issue};
            o_data_ch0_val <= pipe[MEM_LATENCY-1];
            o_data_ch1_val <= pipe[MEM_LATENCY-1];
            o_data_ch2_val <= pipe[MEM_LATENCY-1];
            if (pipe[MEM_LATENCY-1]) begin
                o_data_ch0 <= mem_rdata[0*DAT_WIDTH +: DAT_WIDTH];
                o_data_ch1 <= mem_rdata[1*DAT_WIDTH +: DAT_WIDTH];
                o_data_ch2 <= mem_rdata[2*DAT_WIDTH +: DAT_WIDTH];
            end
        end
    end

`ifdef INPUT_FEEDER_STALL_CNT_EN
    // count RUN cycles blocked only by missing credit, saturating
    always_ff @(posedge clk) begin
        if (rst) stall_cycles <= '0;
        else if (state == IDLE && start) stall_cycles <= '0;
        else if (state == RUN && remaining != '0 && !credit_ok && stall_cycles != 16'hFFFF)
            stall_cycles <= stall_cycles + 16'd1;
    end
`endif
endmodule
